// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receive controller and its FIFO.
package i2s_pkg;

    // Default geometry of the receiver.
    localparam int I2S_DATA_W = 18;
    localparam int I2S_SLOT_W = 32;
    localparam int I2S_FIFO_D = 4;

    // Channel encoding carried on ws and stored with every captured word.
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous FIFO with a registered read port. A push into a full FIFO is
// dropped unless a pop frees a slot on the same edge. The output register
// is loaded with the word that will be at the head after this edge, so a
// push into an empty FIFO shows up on rdata exactly one cycle later.
module i2s_rx_fifo #(
    parameter int W  = 19,
    parameter int D  = 4,
    localparam int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          ready,
    output logic [W-1:0]  rdata,
    output logic          valid,
    output logic [AW:0]   level,
    output logic          dropped
);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [W-1:0]  rdata_reg;
    logic          full;
    logic          pop;
    logic          push_acc;

    assign valid    = (count_reg != '0);
    assign full     = (count_reg == (AW+1)'(D));
    assign pop      = valid && ready;
    assign push_acc = push && (!full || pop);
    assign dropped  = push && full && !pop;
    assign level    = count_reg;
    assign rdata    = rdata_reg;

    // Read pointer as it will be after this edge.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
    end

    // Storage array; kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push_acc, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            // The word being written becomes the head when the FIFO is
            // (or is about to be) empty; the array has not absorbed it yet.
            if (push_acc && (wr_ptr_reg == rd_ptr_next)) begin
                rdata_reg <= wdata;
            end else begin
                rdata_reg <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S master receiver: generates sck/ws for a microphone, deserialises
// MSB-first samples on sck falling edges and queues {channel, sample}.
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W,
    parameter int SLOT_W = I2S_SLOT_W,
    parameter int FIFO_D = I2S_FIFO_D
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [7:0]                prescale,
    output logic                      sck,
    output logic                      ws,
    input  logic                      sdi,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(FIFO_D):0]   level,
    output logic                      overrun,
    input  logic                      clr_ovr
);

    localparam int BW = $clog2(SLOT_W);

    logic              en_d_reg;
    logic [7:0]        presc_reg;
    logic [7:0]        div_reg;
    logic              sck_reg;
    logic              ws_reg;
    logic [BW-1:0]     b_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] word_next;
    logic              overrun_reg;

    logic [7:0]        eff_presc;
    logic              tc;
    logic              fall_ev;
    logic              b_last;
    logic              push;
    logic              dropped;
    logic [DATA_W:0]   fifo_rdata;

    // On the first enabled edge the live prescale is used so that the very
    // first half period already has the newly latched length.
    assign eff_presc = en_d_reg ? presc_reg : prescale;
    assign tc        = (div_reg == eff_presc);
    assign fall_ev   = en && tc && sck_reg;
    assign b_last    = (b_reg == BW'(SLOT_W - 1));
    assign push      = fall_ev && (b_reg == BW'(DATA_W - 1));

    // Slot word with the current sdi merged at the bit selected by b;
    // positions b >= DATA_W match no bit and leave the word untouched.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            assign word_next[gi] = (b_reg == BW'(DATA_W - 1 - gi)) ? sdi : shift_reg[gi];
        end
    endgenerate

    // Divider, bit clock, slot counter, word select and shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d_reg  <= 1'b0;
            presc_reg <= '0;
            div_reg   <= '0;
            sck_reg   <= 1'b0;
            ws_reg    <= CH_LEFT;
            b_reg     <= '0;
            shift_reg <= '0;
        end else if (!en) begin
            en_d_reg  <= 1'b0;
            div_reg   <= '0;
            sck_reg   <= 1'b0;
            ws_reg    <= CH_LEFT;
            b_reg     <= '0;
            shift_reg <= '0;
        end else begin
            en_d_reg <= 1'b1;
            if (!en_d_reg) begin
                presc_reg <= prescale;
            end
            if (tc) begin
                div_reg <= '0;
                sck_reg <= ~sck_reg;
            end else begin
                div_reg <= div_reg + 8'd1;
            end
            if (fall_ev) begin
                shift_reg <= word_next;
                if (b_last) begin
                    b_reg  <= '0;
                    ws_reg <= (ws_reg == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                end else begin
                    b_reg <= b_reg + BW'(1);
                end
            end
        end
    end

    // Sticky overrun; a drop on the same edge beats the clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_reg <= 1'b0;
        end else if (dropped) begin
            overrun_reg <= 1'b1;
        end else if (clr_ovr) begin
            overrun_reg <= 1'b0;
        end
    end

    i2s_rx_fifo #(
        .W (DATA_W + 1),
        .D (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   ({ws_reg, word_next}),
        .ready   (out_ready),
        .rdata   (fifo_rdata),
        .valid   (out_valid),
        .level   (level),
        .dropped (dropped)
    );

    assign sck      = sck_reg;
    assign ws       = ws_reg;
    assign overrun  = overrun_reg;
    assign out_ch   = fifo_rdata[DATA_W];
    assign out_data = fifo_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: a microphone model plus a frame/FIFO reference
// model computed from the edge count since enable.
module tb_i2s_rx_ctrl;
    import i2s_pkg::*;

    localparam int DW = I2S_DATA_W;
    localparam int SW = I2S_SLOT_W;
    localparam int FD = I2S_FIFO_D;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [7:0]    prescale = 8'd0;
    logic          sck;
    logic          ws;
    logic          sdi = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_ch;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LW-1:0] level;
    logic          overrun;
    logic          clr_ovr = 1'b0;

    always #5 clk = ~clk;

    i2s_rx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .prescale  (prescale),
        .sck       (sck),
        .ws        (ws),
        .sdi       (sdi),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: FIFO contents, edges since enable, latched prescale.
    logic [DW:0]   mq[$];
    int            n       = 0;
    bit            en_prev = 0;
    int            p_lat   = 0;
    bit            m_ovr   = 0;
    bit            fixed_mode = 1;
    logic [DW-1:0] rnd_w [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] slot_word(input int s);
        logic [DW-1:0] l_w = DW'(18'h10A0B);
        logic [DW-1:0] r_w = DW'(18'h20D0F);
        if (fixed_mode) return (s % 2 == 1) ? r_w : l_w;
        return rnd_w[s % 64];
    endfunction

    // Advance one clock, update the model for the edge just taken, compare,
    // and let the microphone drive its next bit after a sck rise.
    task automatic cycle();
        bit            pop;
        bit            drop;
        int            P;
        int            k;
        int            b;
        int            s;
        logic [DW-1:0] w;
        logic [DW:0]   head;
        @(posedge clk);
        @(negedge clk);
        drop = 0;
        if (rst) begin
            mq.delete();
            m_ovr   = 0;
            n       = 0;
            en_prev = 0;
            p_lat   = 0;
        end else begin
            pop = (mq.size() > 0) && out_ready;
            if (pop) begin
                head = mq.pop_front();
                $display("word ch=%0d data=%05h", head[DW], head[DW-1:0]);
            end
            if (!en) begin
                n       = 0;
                en_prev = 0;
            end else begin
                if (!en_prev) p_lat = prescale;
                en_prev = 1;
                n++;
                P = p_lat + 1;
                if (n % (2 * P) == 0) begin
                    k = n / (2 * P);
                    b = (k - 1) % SW;
                    s = (k - 1) / SW;
                    if (b == DW - 1) begin
                        w = slot_word(s);
                        if (mq.size() < FD) mq.push_back({1'(s % 2), w});
                        else drop = 1;
                    end
                end
            end
            if (drop) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
        end
        P = p_lat + 1;
        check("sck", 64'(sck), en_prev ? 64'((n / P) % 2) : 64'd0);
        check("ws", 64'(ws), en_prev ? 64'(((n / (2 * P)) / SW) % 2) : 64'd0);
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("level", 64'(level), 64'(mq.size()));
        check("overrun", 64'(overrun), 64'(m_ovr));
        if (mq.size() > 0) check("out_word", 64'({out_ch, out_data}), 64'(mq[0]));
        if (en_prev && (n % (2 * P) == P)) begin
            k = n / (2 * P) + 1;
            b = (k - 1) % SW;
            s = (k - 1) / SW;
            w = slot_word(s);
            sdi = (b < DW) ? w[DW - 1 - b] : 1'($urandom);
        end
    endtask

    // True when the coming edge is a fall that completes a sample.
    function automatic bit push_next();
        int P  = p_lat + 1;
        int nn = n + 1;
        if (!en_prev || (nn % (2 * P) != 0)) return 0;
        return (((nn / (2 * P)) - 1) % SW) == DW - 1;
    endfunction

    initial begin
        int budget;
        for (int i = 0; i < 64; i++) rnd_w[i] = DW'($urandom);

        // Reset held with en=1.
        rst = 1'b1; en = 1'b1; prescale = 8'd1;
        repeat (3) cycle();
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ch", 64'(out_ch), 64'd0);
        rst = 1'b0;

        // Basic capture; prescale wiggles while enabled and must be ignored.
        for (int i = 0; i < 6 * 128; i++) begin
            cycle();
            prescale = 8'($urandom_range(0, 7));
        end

        // Backpressure over five slots, then drain and clear overrun.
        out_ready = 1'b0;
        repeat (5 * 128) cycle();
        check("bp_level", 64'(level), 64'(FD));
        check("bp_overrun", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        repeat (FD) cycle();
        out_ready = 1'b0;
        clr_ovr = 1'b1;
        cycle();
        clr_ovr = 1'b0;
        check("clr_overrun", 64'(overrun), 64'd0);

        // Refill, then pop on exactly the edge of the next push.
        budget = 2000;
        while (mq.size() < FD && budget > 0) begin cycle(); budget--; end
        check("fill_timeout", 64'(budget > 0), 64'd1);
        budget = 2000;
        while (!push_next() && budget > 0) begin cycle(); budget--; end
        check("push_timeout", 64'(budget > 0), 64'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("popush_level", 64'(level), 64'(FD));
        check("popush_ovr", 64'(overrun), 64'd0);
        out_ready = 1'b1;
        repeat (8) cycle();

        // Drop en at b=9 of a left slot, then re-enable.
        budget = 2000;
        while (!(en_prev && ((n / 4) % SW == 9) && (((n / 4) / SW) % 2 == 0) && (n % 4 == 0))
               && budget > 0) begin
            cycle(); budget--;
        end
        check("b9_timeout", 64'(budget > 0), 64'd1);
        en = 1'b0;
        cycle();
        check("dis_sck", 64'(sck), 64'd0);
        check("dis_ws", 64'(ws), 64'd0);
        repeat (3) cycle();
        en = 1'b1;
        prescale = 8'd1;
        repeat (2 * 128) cycle();

        // Reset during a right slot with two words queued.
        out_ready = 1'b0;
        budget = 2000;
        while (!(mq.size() == 2 && ws === CH_RIGHT) && budget > 0) begin cycle(); budget--; end
        check("q2_timeout", 64'(budget > 0), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3 * 128) cycle();

        // Randomised sessions: words, prescale, backpressure, clears, restarts.
        for (int sess = 0; sess < 8; sess++) begin
            int len;
            en = 1'b0;
            repeat ($urandom_range(1, 5)) cycle();
            fixed_mode = ($urandom % 3 == 0);
            for (int i = 0; i < 64; i++) rnd_w[i] = DW'($urandom);
            prescale = 8'($urandom_range(0, 3));
            en = 1'b1;
            len = $urandom_range(300, 2500);
            for (int c = 0; c < len; c++) begin
                out_ready = ($urandom % 4 != 0) || (sess % 3 == 1 && $urandom % 2 == 0);
                if (sess % 3 == 2) out_ready = ($urandom % 8 == 0);
                clr_ovr = ($urandom % 64 == 0);
                rst = (c > 50 && $urandom % 1500 == 0);
                cycle();
                prescale = 8'($urandom);
            end
            clr_ovr = 1'b0;
            rst = 1'b0;
            out_ready = 1'b1;
        end
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_rx_ctrl.md
I2S_RX_CTRL -- requirements
Module: i2s_rx_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst are the only clock and reset ports.
REQ-002 Parameter DATA_W, default 18: received sample width in bits.
REQ-003 Parameter SLOT_W, default 32: sck periods per channel slot; SLOT_W >= DATA_W+1.
REQ-004 Parameter FIFO_D, default 4: output FIFO depth in words; power of 2.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 en  in  1  enables frame generation and capture.
REQ-008 prescale  in  8  sck half-period minus one, in clk cycles.
REQ-009 sck  out  1  I2S bit clock to the microphone.
REQ-010 ws  out  1  word select: 0 = left, 1 = right.
REQ-011 sdi  in  1  serial data from the microphone; it changes after sck rises.
REQ-012 out_data  out  DATA_W  received sample, MSB-aligned.
REQ-013 out_ch  out  1  channel of out_data: 0 = left, 1 = right.
REQ-014 out_valid  out  1  FIFO not empty.
REQ-015 out_ready  in  1  consumer accepts the word.
REQ-016 level  out  $clog2(FIFO_D)+1  FIFO occupancy.
REQ-017 overrun  out  1  sticky flag: a word was dropped.
REQ-018 clr_ovr  in  1  single-cycle pulse that clears overrun.

Function
REQ-019 When en rises, prescale SHALL be latched; prescale changes while en=1 SHALL be ignored.
REQ-020 Clock generation SHALL use a divider counter that runs 0..prescale and toggles sck at terminal count.
- sck half-period = prescale+1 clk cycles.
- prescale=0 gives sck = clk/2.
REQ-021 A fall event is the clk edge that drives sck from 1 to 0; a rise event is the clk edge that drives sck from 0 to 1.
REQ-022 Slot timing SHALL use a bit counter b, range 0..SLOT_W-1, which increments on each fall event.
- When b wraps from SLOT_W-1 to 0, ws toggles on that same fall event.
REQ-023 On a fall event with pre-increment b in 0..DATA_W-1, the value of sdi at that edge SHALL be shifted into bit DATA_W-1-b of the current slot word (MSB first).
REQ-024 On the fall event with pre-increment b = DATA_W-1, the completed word and ch = current ws SHALL be pushed to the FIFO.
- out_valid rises on the next clk edge when the FIFO was empty.
REQ-025 Bits at slot positions b >= DATA_W SHALL be ignored.
REQ-026 The FIFO SHALL pop when out_valid && out_ready; words are delivered in capture order.
REQ-027 A push into a full FIFO SHALL drop the new word and set overrun.
- If a pop occurs in the same cycle, the push SHALL be accepted and overrun SHALL NOT be set.
REQ-028 Push into an empty FIFO with out_ready=1 SHALL NOT bypass: the word appears on out_data one cycle later.
REQ-029 clr_ovr SHALL clear overrun, except that a same-cycle drop SHALL win and overrun stays 1.
REQ-030 When en=0, the block SHALL, on the next edge:
- force sck=0 and ws=0;
- clear the divider and b;
- discard any partial word.
- FIFO contents and overrun SHALL be kept.
REQ-031 When en rises, the first frame SHALL begin with a left slot, b=0, and sck low for prescale+1 cycles.

Reset
REQ-032 rst SHALL set sck=0, ws=0, out_valid=0, level=0, overrun=0, out_data=0, out_ch=0, all counters to 0, and the latched prescale to 0.
REQ-033 rst asserted mid-frame SHALL override all other inputs.
- The FIFO is emptied and partial words are discarded.

Structure
REQ-034 A shared package i2s_pkg SHALL hold:
- the DATA_W/SLOT_W/FIFO_D defaults;
- the channel encoding constants CH_LEFT=0 and CH_RIGHT=1.
REQ-035 The FIFO SHALL be one sub-module, i2s_rx_fifo, with a width of DATA_W+1 bits.
REQ-036 Divider, slot counter and shifter SHALL stay in i2s_rx_ctrl.

Verification
REQ-037 Reset: rst=1 for 3 cycles with en=1 -> sck=0, ws=0, out_valid=0, level=0, overrun=0.
REQ-038 Basic capture, with a microphone model sending left 18'h10A0B and right 18'h20D0F, prescale=1, out_ready=1:
- sck period is 4 clk and ws toggles every 128 clk;
- words {ch0, 0x10A0B}, then {ch1, 0x20D0F}, repeating.
REQ-039 Backpressure: out_ready=0 for 5 slots -> level=4 and overrun=1.
- Reads then return L, R, L, R in order.
- clr_ovr -> overrun=0.
REQ-040 Full FIFO with a pop in the same cycle as a push -> word accepted, level stays 4, overrun stays 0.
REQ-041 Enable restart: en dropped at b=9 of a left slot -> sck=0 and ws=0 next cycle, and no word is pushed.
- Re-enable -> the next word is {ch0, 0x10A0B}.
REQ-042 rst during the right slot with 2 words queued -> level=0, out_valid=0.
- Capture resumes after rst, starting with the left slot.
